// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, mux selects,
// default ALU codes and the registered control-word layout.
package ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALUWB  = 4'd4,
    S_ADDIEX = 4'd5,
    S_ADDIWB = 4'd6,
    S_MEMADR = 4'd7,
    S_MEMRD  = 4'd8,
    S_MEMWB  = 4'd9,
    S_MEMWR  = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [1:0] ALU_SRC_B_REG   = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMMSH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_SUB   = 2'd1,
    ALU_CLS_FUNCT = 2'd2
  } alu_cls_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       instr_done;
  } ctrl_t;

  // State-only part of the control word; mem_ready-gated terms are added in the top.
  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = ALU_SRC_B_FOUR;
        c.pc_src    = PC_SRC_ALU;
      end
      S_DECODE: c.alu_src_b = ALU_SRC_B_IMMSH;
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALU_SRC_B_REG;
      end
      S_ALUWB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_ADDIEX, S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = ALU_SRC_B_IMM;
      end
      S_ADDIWB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.i_or_d  = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = ALU_SRC_B_REG;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PC_SRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_src     = PC_SRC_JUMP;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Selects the ALU operation: fixed add/subtract, or the instruction's funct field.
module alu_decoder
  import ctrl_pkg::*;
#(
  parameter int unsigned FUNCT_W = 3
) (
  input  alu_cls_e             cls_i,
  input  logic [FUNCT_W-1:0]   funct_i,
  output logic [FUNCT_W-1:0]   alu_control_o
);

  always_comb begin
    alu_control_o = FUNCT_W'(ALU_ADD);
    case (cls_i)
      ALU_CLS_SUB:   alu_control_o = FUNCT_W'(ALU_SUB);
      ALU_CLS_FUNCT: alu_control_o = funct_i;
      default:       alu_control_o = FUNCT_W'(ALU_ADD);
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore controller sequencing fetch/decode/execute/memory/writeback over a shared
// datapath; control word is registered from the next state, handshake terms are gated live.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned        OP_W     = 4,
  parameter int unsigned        FUNCT_W  = 3,
  parameter logic [OP_W-1:0]    OP_RTYPE = OP_W'(4'b0000),
  parameter logic [OP_W-1:0]    OP_ADDI  = OP_W'(4'b0100),
  parameter logic [OP_W-1:0]    OP_LW    = OP_W'(4'b1011),
  parameter logic [OP_W-1:0]    OP_SW    = OP_W'(4'b1111),
  parameter logic [OP_W-1:0]    OP_BEQ   = OP_W'(4'b1000),
  parameter logic [OP_W-1:0]    OP_J     = OP_W'(4'b0010)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [FUNCT_W-1:0] alu_control,
  output logic               instr_done,
  output logic               illegal_op
);

  state_e               state_q, state_d;
  ctrl_t                ctrl_q;
  logic [FUNCT_W-1:0]   alu_control_q, alu_control_d;
  alu_cls_e             alu_cls_d;
  logic                 known_op;

  assign known_op = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
                    (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == OP_RTYPE)                   state_d = S_EXEC;
        else if (op == OP_ADDI)               state_d = S_ADDIEX;
        else if ((op == OP_LW) || (op == OP_SW)) state_d = S_MEMADR;
        else if (op == OP_BEQ)                state_d = S_BRANCH;
        else if (op == OP_J)                  state_d = S_JUMP;
        else                                  state_d = S_FETCH;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_ALUWB, S_ADDIWB, S_MEMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // ALU class follows the state being entered so alu_control is registered with it.
  always_comb begin
    alu_cls_d = ALU_CLS_ADD;
    if (state_d == S_EXEC)        alu_cls_d = ALU_CLS_FUNCT;
    else if (state_d == S_BRANCH) alu_cls_d = ALU_CLS_SUB;
  end

  alu_decoder #(
    .FUNCT_W (FUNCT_W)
  ) u_alu_decoder (
    .cls_i         (alu_cls_d),
    .funct_i       (funct),
    .alu_control_o (alu_control_d)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ctrl_q        <= '0;
      alu_control_q <= '0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= state_ctrl(state_d);
      alu_control_q <= alu_control_d;
    end
  end

  assign mem_req       = ctrl_q.mem_req;
  assign mem_we        = ctrl_q.mem_we;
  assign i_or_d        = ctrl_q.i_or_d;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign reg_write     = ctrl_q.reg_write;
  assign reg_dst       = ctrl_q.reg_dst;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign pc_src        = ctrl_q.pc_src;
  assign alu_control   = alu_control_q;

  // Handshake-completion and opcode-check terms depend on live inputs.
  assign ir_write   = (state_q == S_FETCH) && mem_ready;
  assign pc_write   = ctrl_q.pc_write || ir_write;
  assign instr_done = ctrl_q.instr_done || ((state_q == S_MEMWR) && mem_ready);
  assign illegal_op = (state_q == S_DECODE) && !known_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: a cycle-timeline model of each instruction class predicts every output
// per cycle; literal latencies and ALU codes pin the model.
module tb_multicycle_control;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b0010;
  localparam logic [3:0] OP_BAD  = 4'b0111;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] op;
  logic [2:0] funct;
  logic       mem_ready;
  logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .op            (op),
    .funct         (funct),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_src        (pc_src),
    .alu_control   (alu_control),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

  logic [18:0] act_vec;
  assign act_vec = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_control,
                    instr_done, illegal_op};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        chk_en   = 1'b0;
  logic [18:0] exp_vec  = '0;
  string       chk_name = "";
  int          chk_cyc  = 0;
  int          done_cyc = 0;
  logic [2:0]  last_exec_alu = 3'b000;

  // Instruction timeline: (wf+1) fetch cycles, one decode cycle, then class-specific phases.
  function automatic int instr_len(input logic [3:0] o, input int wf, input int wm);
    int base;
    base = wf + 2;
    case (o)
      OP_R, OP_ADDI: return base + 2;
      OP_LW:         return base + wm + 3;
      OP_SW:         return base + wm + 2;
      OP_BEQ, OP_J:  return base + 1;
      default:       return base;
    endcase
  endfunction

  function automatic logic ready_at(input logic [3:0] o, input int wf, input int wm, input int k);
    if (k < wf)  return 1'b0;
    if (k == wf) return 1'b1;
    if (((o == OP_LW) || (o == OP_SW)) && (k >= wf + 3)) return (k == wf + 3 + wm);
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [18:0] expect_at(input logic [3:0] o, input logic [2:0] fn,
                                            input int wf, input int wm, input int k);
    logic req, we, iod, irw, pcw, pcc, rw, rd, m2r, sa, done, ill;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    int j;
    {req, we, iod, irw, pcw, pcc, rw, rd, m2r, sa, done, ill} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b000;
    j = k - (wf + 2);
    if (k <= wf) begin
      req = 1'b1; sb = 2'b01;
      irw = (k == wf); pcw = (k == wf);
    end else if (k == wf + 1) begin
      sb  = 2'b11;
      ill = !((o == OP_R) || (o == OP_ADDI) || (o == OP_LW) || (o == OP_SW) ||
              (o == OP_BEQ) || (o == OP_J));
    end else begin
      case (o)
        OP_R: if (j == 0) begin sa = 1'b1; alu = fn; end
              else begin rd = 1'b1; rw = 1'b1; done = 1'b1; end
        OP_ADDI: if (j == 0) begin sa = 1'b1; sb = 2'b10; end
                 else begin rw = 1'b1; done = 1'b1; end
        OP_LW: if (j == 0) begin sa = 1'b1; sb = 2'b10; end
               else if (j <= wm + 1) begin req = 1'b1; iod = 1'b1; end
               else begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
        OP_SW: if (j == 0) begin sa = 1'b1; sb = 2'b10; end
               else begin req = 1'b1; we = 1'b1; iod = 1'b1; done = (j == wm + 1); end
        OP_BEQ: begin sa = 1'b1; alu = 3'b001; pcc = 1'b1; ps = 2'b01; done = 1'b1; end
        OP_J:   begin pcw = 1'b1; ps = 2'b10; done = 1'b1; end
        default: ;
      endcase
    end
    return {req, we, iod, irw, pcw, pcc, rw, rd, m2r, sa, sb, ps, alu, done, ill};
  endfunction

  // Single compare point, mid-cycle, against the model's prediction.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b", chk_name, chk_cyc, act_vec, exp_vec);
      end
      if ((instr_done === 1'b1) && (done_cyc == 0)) done_cyc = chk_cyc + 1;
      if ((alu_src_a === 1'b1) && (alu_src_b === 2'b00) && (pc_write_cond === 1'b0))
        last_exec_alu = alu_control;
    end
  end

  task automatic check_lit(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // abort_at >= 0 pulls reset_n low during that cycle; exp_len is the hand-computed latency.
  task automatic run_instr(input string name, input logic [3:0] o, input logic [2:0] fn,
                           input int wf, input int wm, input int abort_at, input int exp_len);
    int len;
    logic aborted;
    len = instr_len(o, wf, wm);
    aborted = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #2;
      op = o; funct = fn;
      mem_ready = ready_at(o, wf, wm, k);
      exp_vec = expect_at(o, fn, wf, wm, k);
      chk_name = name; chk_cyc = k; chk_en = 1'b1;
      if (k == abort_at) begin
        reset_n = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(posedge clk); #2;
      reset_n = 1'b1;
      mem_ready = 1'b1;
      exp_vec = '0;
      chk_name = {name, "_idle"}; chk_cyc = 0;
      @(negedge clk); #1;
      check_lit({name, "_no_done"}, done_cyc, 0);
    end else begin
      @(negedge clk); #1;
      check_lit({name, "_latency"}, done_cyc, exp_len);
    end
  endtask

  initial begin
    reset_n = 1'b0; op = 4'b0000; funct = 3'b000; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1; mem_ready = 1'b1;
    exp_vec = '0; chk_name = "idle_after_reset"; chk_cyc = 0; chk_en = 1'b1;

    run_instr("rtype_f010", OP_R, 3'b010, 0, 0, -1, 4);
    check_lit("rtype_exec_alu", int'(last_exec_alu), 2);
    run_instr("addi_fwait1", OP_ADDI, 3'b000, 1, 0, -1, 5);
    run_instr("lw_wait3", OP_LW, 3'b000, 0, 3, -1, 8);
    run_instr("sw_wait2", OP_SW, 3'b000, 0, 2, -1, 6);
    run_instr("sw_nowait", OP_SW, 3'b000, 0, 0, -1, 4);
    run_instr("beq", OP_BEQ, 3'b000, 0, 0, -1, 3);
    check_lit("beq_alu_sub_not_exec", int'(last_exec_alu), 2);
    run_instr("jump", OP_J, 3'b000, 0, 0, -1, 3);
    run_instr("rtype_f101_fwait2", OP_R, 3'b101, 2, 0, -1, 6);
    check_lit("rtype_exec_alu2", int'(last_exec_alu), 5);
    run_instr("illegal_0111", OP_BAD, 3'b000, 0, 0, -1, 0);
    run_instr("lw_abort", OP_LW, 3'b000, 0, 5, 4, 0);
    run_instr("jump_after_abort", OP_J, 3'b000, 0, 0, -1, 3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
